// File: rtl/lsu_response_merger.sv
// lsu_response_merger
//   Collects the per-cache-line memory responses produced for one warp memory
//   instruction, accumulates lane data in a per-warp slot, and emits a single
//   merged register writeback once the last split of that warp has arrived.
//
//   Optional feature macro: LSU_MERGE_OVERLAP_CHECK_EN
//     defined   -> sticky err_overlap on overlapping lanes or rd mismatch
//     undefined -> check not built, err_overlap tied to 0
//
//   Handshakes (both ports): a transfer happens on a rising edge where valid
//   and ready are both high. resp_ready depends only on resp_warp and slot
//   state, never on resp_valid. Once wb_valid is high, wb_* stay stable until
//   wb_ready is seen.
//
//   dbg_slot_state exposes each slot FSM (2 bits per warp, warp 0 in [1:0]).
module lsu_response_merger #(
  parameter int WARP_SIZE = 32,
  parameter int NUM_WARPS = 4,
  parameter int DATA_W    = 32,
  parameter int REG_W     = 6,
  localparam int WID_W    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int LINE_W   = WARP_SIZE * DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   resp_valid,
  output logic                   resp_ready,
  input  logic [WID_W-1:0]       resp_warp,
  input  logic [REG_W-1:0]       resp_rd,
  input  logic [WARP_SIZE-1:0]   resp_mask,
  input  logic [LINE_W-1:0]      resp_data,
  input  logic                   resp_last,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [WID_W-1:0]       wb_warp,
  output logic [REG_W-1:0]       wb_rd,
  output logic [WARP_SIZE-1:0]   wb_mask,
  output logic [LINE_W-1:0]      wb_data,
  output logic                   err_overlap,
  output logic [2*NUM_WARPS-1:0] dbg_slot_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } slot_state_t;

  // Per-warp slot storage
  slot_state_t          r_state     [NUM_WARPS];
  slot_state_t          w_state_nxt [NUM_WARPS];
  logic [LINE_W-1:0]    r_data      [NUM_WARPS];
  logic [WARP_SIZE-1:0] r_mask      [NUM_WARPS];
  logic [REG_W-1:0]     r_rd        [NUM_WARPS];

  // Output register and arbiter pointer
  logic                 r_wb_valid;
  logic [WID_W-1:0]     r_wb_warp;
  logic [REG_W-1:0]     r_wb_rd;
  logic [WARP_SIZE-1:0] r_wb_mask;
  logic [LINE_W-1:0]    r_wb_data;
  logic [WID_W-1:0]     r_ptr;

  logic                 w_accept;
  logic                 w_beat_last;
  logic                 w_wb_fire;
  logic                 w_out_free;
  logic                 w_slot_idle;
  logic [LINE_W-1:0]    w_merged_data;
  logic [WARP_SIZE-1:0] w_merged_mask;
  logic [REG_W-1:0]     w_merged_rd;
  logic [NUM_WARPS-1:0] w_cand;
  logic [WID_W-1:0]     w_rr_base;
  logic [WID_W-1:0]     w_sel;
  logic                 w_sel_found;
  int                   w_idx;

  assign resp_ready  = (r_state[resp_warp] != S_DONE);
  assign w_accept    = resp_valid && resp_ready;
  assign w_beat_last = w_accept && resp_last;
  assign w_wb_fire   = r_wb_valid && wb_ready;
  assign w_out_free  = !r_wb_valid || wb_ready;

  assign wb_valid = r_wb_valid;
  assign wb_warp  = r_wb_warp;
  assign wb_rd    = r_wb_rd;
  assign wb_mask  = r_wb_mask;
  assign wb_data  = r_wb_data;

  // Slot FSM state register
  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (rst) r_state[w] <= S_IDLE;
      else     r_state[w] <= w_state_nxt[w];
    end
  end

  // Slot FSM next state: beats advance IDLE/ACCUM, writeback handshake frees DONE
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_state_nxt[w] = r_state[w];
      case (r_state[w])
        S_IDLE, S_ACCUM: begin
          if (w_accept && (int'(resp_warp) == w))
            w_state_nxt[w] = resp_last ? S_DONE : S_ACCUM;
        end
        S_DONE: begin
          if (w_wb_fire && (int'(r_wb_warp) == w))
            w_state_nxt[w] = S_IDLE;
        end
        default: w_state_nxt[w] = S_IDLE;
      endcase
    end
  end

  // Merge the incoming beat onto the slot contents (an IDLE slot starts from zero)
  always_comb begin
    w_slot_idle   = (r_state[resp_warp] == S_IDLE);
    w_merged_data = w_slot_idle ? '0 : r_data[resp_warp];
    w_merged_mask = (w_slot_idle ? '0 : r_mask[resp_warp]) | resp_mask;
    w_merged_rd   = w_slot_idle ? resp_rd : r_rd[resp_warp];
    for (int i = 0; i < WARP_SIZE; i++) begin
      if (resp_mask[i])
        w_merged_data[i*DATA_W +: DATA_W] = resp_data[i*DATA_W +: DATA_W];
    end
  end

  // Slot storage: no reset needed, the first beat into an IDLE slot rebuilds it
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_data[resp_warp] <= w_merged_data;
      r_mask[resp_warp] <= w_merged_mask;
      r_rd[resp_warp]   <= w_merged_rd;
    end
  end

  // Round-robin pick among DONE slots; a final beat landing this cycle is also
  // eligible so its writeback appears one cycle after acceptance
  always_comb begin
    w_rr_base = w_wb_fire ? WID_W'((int'(r_wb_warp) + 1) % NUM_WARPS) : r_ptr;
    w_cand    = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_cand[w] = ((r_state[w] == S_DONE) && !(r_wb_valid && (int'(r_wb_warp) == w)))
                || (w_beat_last && (int'(resp_warp) == w));
    end
    w_sel_found = 1'b0;
    w_sel       = '0;
    w_idx       = 0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      w_idx = (int'(w_rr_base) + i) % NUM_WARPS;
      if (!w_sel_found && w_cand[w_idx]) begin
        w_sel_found = 1'b1;
        w_sel       = WID_W'(w_idx);
      end
    end
  end

  // Arbiter pointer advances past the granted warp on each handshake
  always_ff @(posedge clk) begin
    if (rst)            r_ptr <= '0;
    else if (w_wb_fire) r_ptr <= w_rr_base;
  end

  // Output register: reloads only when empty or being consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_warp  <= '0;
      r_wb_rd    <= '0;
      r_wb_mask  <= '0;
      r_wb_data  <= '0;
    end else if (w_out_free) begin
      r_wb_valid <= w_sel_found;
      if (w_sel_found) begin
        r_wb_warp <= w_sel;
        if (w_beat_last && (resp_warp == w_sel)) begin
          r_wb_rd   <= w_merged_rd;
          r_wb_mask <= w_merged_mask;
          r_wb_data <= w_merged_data;
        end else begin
          r_wb_rd   <= r_rd[w_sel];
          r_wb_mask <= r_mask[w_sel];
          r_wb_data <= r_data[w_sel];
        end
      end
    end
  end

`ifdef LSU_MERGE_OVERLAP_CHECK_EN
  logic r_err_overlap;

  // Sticky flag: a continuation beat re-wrote a lane or disagreed on rd
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_overlap <= 1'b0;
    end else if (w_accept && (r_state[resp_warp] == S_ACCUM) &&
                 (((resp_mask & r_mask[resp_warp]) != '0) || (resp_rd != r_rd[resp_warp]))) begin
      r_err_overlap <= 1'b1;
    end
  end

  assign err_overlap = r_err_overlap;
`else
  assign err_overlap = 1'b0;
`endif

  // Debug view of every slot FSM
  always_comb begin
    dbg_slot_state = '0;
    for (int w = 0; w < NUM_WARPS; w++) dbg_slot_state[2*w +: 2] = r_state[w];
  end

endmodule

// File: tb/tb_lsu_response_merger.sv
// Testbench for lsu_response_merger: directed scenarios plus a randomized
// phase, checked against a lane-level reference model of the merge rules.
module tb_lsu_response_merger;
  localparam int WARP_SIZE = 32;
  localparam int NUM_WARPS = 4;
  localparam int DATA_W    = 32;
  localparam int REG_W     = 6;
  localparam int WID_W     = 2;
  localparam int LINE_W    = WARP_SIZE * DATA_W;
  localparam int REC_W     = WID_W + REG_W + WARP_SIZE + LINE_W;

  // ---------------- clock / reset / DUT ----------------
  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   resp_valid = 1'b0;
  logic                   resp_ready;
  logic [WID_W-1:0]       resp_warp = '0;
  logic [REG_W-1:0]       resp_rd = '0;
  logic [WARP_SIZE-1:0]   resp_mask = '0;
  logic [LINE_W-1:0]      resp_data = '0;
  logic                   resp_last = 1'b0;
  logic                   wb_valid;
  logic                   wb_ready = 1'b1;
  logic [WID_W-1:0]       wb_warp;
  logic [REG_W-1:0]       wb_rd;
  logic [WARP_SIZE-1:0]   wb_mask;
  logic [LINE_W-1:0]      wb_data;
  logic                   err_overlap;
  logic [2*NUM_WARPS-1:0] dbg_slot_state;

  always #5 clk = ~clk;

  lsu_response_merger dut (
    .clk(clk), .rst(rst),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_warp(resp_warp),
    .resp_rd(resp_rd), .resp_mask(resp_mask), .resp_data(resp_data), .resp_last(resp_last),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_warp(wb_warp), .wb_rd(wb_rd),
    .wb_mask(wb_mask), .wb_data(wb_data), .err_overlap(err_overlap),
    .dbg_slot_state(dbg_slot_state)
  );

  int n_checks = 0;
  int n_pass = 0;
  int drv_timeouts = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] got_q[$];
  int               got_t[$];

  // Observed writebacks: captured mid-cycle, ahead of the handshake edge
  always @(negedge clk) begin
    if (!rst && wb_valid === 1'b1 && wb_ready === 1'b1) begin
      got_q.push_back({wb_warp, wb_rd, wb_mask, wb_data});
      got_t.push_back(cyc);
    end
  end

  // ---------------- reference model ----------------
  bit                   m_active [NUM_WARPS];
  logic [REG_W-1:0]     m_rd     [NUM_WARPS];
  logic [WARP_SIZE-1:0] m_mask   [NUM_WARPS];
  logic [DATA_W-1:0]    m_lane   [NUM_WARPS][WARP_SIZE];
  bit                   m_err;

  function automatic void model_reset();
    for (int w = 0; w < NUM_WARPS; w++) m_active[w] = 1'b0;
    m_err = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_beat(int w, logic [REG_W-1:0] rd, logic [WARP_SIZE-1:0] mask,
                                     logic [LINE_W-1:0] data, bit last);
    logic [REC_W-1:0] rec;
    if (!m_active[w]) begin
      m_active[w] = 1'b1;
      m_rd[w]     = rd;
      m_mask[w]   = '0;
      for (int i = 0; i < WARP_SIZE; i++) m_lane[w][i] = '0;
    end else begin
`ifdef LSU_MERGE_OVERLAP_CHECK_EN
      if (((mask & m_mask[w]) != '0) || (rd != m_rd[w])) m_err = 1'b1;
`endif
    end
    for (int i = 0; i < WARP_SIZE; i++)
      if (mask[i]) m_lane[w][i] = data[i*DATA_W +: DATA_W];
    m_mask[w] = m_mask[w] | mask;
    if (last) begin
      rec = '0;
      rec[REC_W-1 -: WID_W]        = WID_W'(w);
      rec[REC_W-WID_W-1 -: REG_W]  = m_rd[w];
      rec[LINE_W +: WARP_SIZE]     = m_mask[w];
      for (int i = 0; i < WARP_SIZE; i++) rec[i*DATA_W +: DATA_W] = m_lane[w][i];
      exp_q.push_back(rec);
      m_active[w] = 1'b0;
    end
  endfunction

  function automatic logic [LINE_W-1:0] pat_line(logic [DATA_W-1:0] base);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < WARP_SIZE; i++) l[i*DATA_W +: DATA_W] = base + DATA_W'(i);
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < WARP_SIZE; i++) l[i*DATA_W +: DATA_W] = $urandom();
    return l;
  endfunction

  function automatic string fmt_rec(logic [REC_W-1:0] r);
    return $sformatf("w%0d rd%0d m%08h l0=%08h l8=%08h l16=%08h l31=%08h",
                     r[REC_W-1 -: WID_W], r[REC_W-WID_W-1 -: REG_W], r[LINE_W +: WARP_SIZE],
                     r[0 +: DATA_W], r[8*DATA_W +: DATA_W], r[16*DATA_W +: DATA_W],
                     r[31*DATA_W +: DATA_W]);
  endfunction

  // ---------------- driver tasks ----------------
  // Starts and ends just after a rising edge. Waits (bounded) for resp_ready;
  // a long wait opens wb_ready so a stalled DONE slot can drain.
  task automatic send_beat(input int w, input logic [REG_W-1:0] rd, input logic [WARP_SIZE-1:0] mask,
                           input logic [LINE_W-1:0] data, input bit last,
                           output int acc_cyc, output int waited);
    int n;
    bit ok;
    n = 0;
    resp_valid = 1'b1;
    resp_warp  = WID_W'(w);
    resp_rd    = rd;
    resp_mask  = mask;
    resp_data  = data;
    resp_last  = last;
    @(negedge clk);
    while (resp_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (n >= 2) wb_ready = 1'b1;
      @(negedge clk);
    end
    ok = (resp_ready === 1'b1);
    waited = n;
    @(posedge clk); #1;
    resp_valid = 1'b0;
    acc_cyc = cyc;
    if (ok) model_beat(w, rd, mask, data, last);
    else    drv_timeouts++;
  endtask

  task automatic wait_got(input int n, output bit ok);
    int k;
    k = 0;
    while (got_q.size() < n && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    ok = (got_q.size() >= n);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    wb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid: got %0b exp 0", wb_valid); else n_pass++;
    n_checks++; if (wb_warp !== '0) $display("FAIL reset_wb_warp: got %0d exp 0", wb_warp); else n_pass++;
    n_checks++; if (wb_rd !== '0) $display("FAIL reset_wb_rd: got %0d exp 0", wb_rd); else n_pass++;
    n_checks++; if (wb_mask !== '0) $display("FAIL reset_wb_mask: got %08h exp 0", wb_mask); else n_pass++;
    n_checks++; if (wb_data !== '0) $display("FAIL reset_wb_data: got nonzero exp 0"); else n_pass++;
    n_checks++; if (err_overlap !== 1'b0) $display("FAIL reset_err: got %0b exp 0", err_overlap); else n_pass++;
    n_checks++; if (dbg_slot_state !== '0) $display("FAIL reset_slots: got %02h exp 00", dbg_slot_state); else n_pass++;
    n_checks++; if (resp_ready !== 1'b1) $display("FAIL reset_resp_ready: got %0b exp 1", resp_ready); else n_pass++;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_coalesced();
    int acc, wt;
    bit ok;
    logic [REC_W-1:0] got, exp;
    int gt;
    send_beat(0, 6'd5, 32'hFFFF_FFFF, pat_line(32'h100), 1'b1, acc, wt);
    wait_got(1, ok);
    n_checks++; if (!ok) $display("FAIL coalesced_wb_seen: got %0d writebacks exp 1", got_q.size()); else n_pass++;
    if (ok) begin
      got = got_q.pop_front(); gt = got_t.pop_front(); exp = exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL coalesced_wb: got %s exp %s", fmt_rec(got), fmt_rec(exp)); else n_pass++;
      n_checks++; if (gt !== acc) $display("FAIL coalesced_latency: got cycle %0d exp %0d", gt, acc); else n_pass++;
    end
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if (got_q.size() !== 0) $display("FAIL coalesced_single: got %0d extra writebacks exp 0", got_q.size()); else n_pass++;
    n_checks++; if (drv_timeouts !== 0) $display("FAIL coalesced_driver: got %0d timeouts exp 0", drv_timeouts); else n_pass++;
  endtask

  task automatic test_two_way_split();
    int acc, wt;
    bit ok;
    logic [REC_W-1:0] got, exp;
    send_beat(1, 6'd9, 32'h0000_FFFF, pat_line(32'hA000), 1'b0, acc, wt);
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (wb_valid !== 1'b0 || got_q.size() !== 0) $display("FAIL split_early_wb: got wb_valid %0b count %0d exp 0", wb_valid, got_q.size()); else n_pass++;
    send_beat(1, 6'd9, 32'hFFFF_0000, pat_line(32'hB000 - 32'd16), 1'b1, acc, wt);
    wait_got(1, ok);
    n_checks++; if (!ok) $display("FAIL split_wb_seen: got %0d exp 1", got_q.size()); else n_pass++;
    if (ok) begin
      got = got_q.pop_front(); void'(got_t.pop_front()); exp = exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL split_wb: got %s exp %s", fmt_rec(got), fmt_rec(exp)); else n_pass++;
    end
  endtask

  task automatic test_interleave();
    int acc, wt;
    bit ok;
    logic [REC_W-1:0] got, exp;
    send_beat(2, 6'd12, 32'h0000_00FF, rand_line(), 1'b0, acc, wt);
    send_beat(3, 6'd33, 32'h0000_FF00, rand_line(), 1'b1, acc, wt);
    send_beat(2, 6'd12, 32'hFFFF_0000, rand_line(), 1'b1, acc, wt);
    wait_got(2, ok);
    n_checks++; if (!ok) $display("FAIL interleave_wb_seen: got %0d exp 2", got_q.size()); else n_pass++;
    if (ok) begin
      for (int k = 0; k < 2; k++) begin
        got = got_q.pop_front(); void'(got_t.pop_front()); exp = exp_q.pop_front();
        n_checks++; if (got !== exp) $display("FAIL interleave_wb%0d: got %s exp %s", k, fmt_rec(got), fmt_rec(exp)); else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure_rr();
    int acc, wt;
    bit ok;
    logic [REC_W-1:0] got, exp, held;
    int t0, t1;
    wb_ready = 1'b0;
    send_beat(0, 6'd1, 32'hFFFF_FFFF, rand_line(), 1'b1, acc, wt);
    send_beat(1, 6'd2, 32'h0F0F_0F0F, rand_line(), 1'b1, acc, wt);
    // probe: warp 0 is DONE and stalled, warp 2 must still be accepted
    resp_valid = 1'b1; resp_warp = 2'd0; resp_mask = 32'hFFFF_FFFF; resp_last = 1'b1;
    @(negedge clk);
    n_checks++; if (resp_ready !== 1'b0) $display("FAIL bp_ready_done_warp: got %0b exp 0", resp_ready); else n_pass++;
    @(posedge clk); #1;
    resp_valid = 1'b0;
    send_beat(2, 6'd3, 32'h0000_00F0, rand_line(), 1'b0, acc, wt);
    n_checks++; if (wt !== 0) $display("FAIL bp_ready_other_warp: got wait %0d exp 0", wt); else n_pass++;
    held = exp_q[0];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({wb_valid, wb_warp, wb_rd, wb_mask, wb_data} !== {1'b1, held})
        $display("FAIL bp_stall_hold%0d: got v%0b %s exp v1 %s", k, wb_valid, fmt_rec({wb_warp, wb_rd, wb_mask, wb_data}), fmt_rec(held));
      else n_pass++;
    end
    @(posedge clk); #1;
    wb_ready = 1'b1;
    wait_got(2, ok);
    n_checks++; if (!ok) $display("FAIL bp_wb_seen: got %0d exp 2", got_q.size()); else n_pass++;
    if (ok) begin
      got = got_q.pop_front(); t0 = got_t.pop_front(); exp = exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL bp_wb_first: got %s exp %s", fmt_rec(got), fmt_rec(exp)); else n_pass++;
      got = got_q.pop_front(); t1 = got_t.pop_front(); exp = exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL bp_wb_second: got %s exp %s", fmt_rec(got), fmt_rec(exp)); else n_pass++;
      n_checks++; if (t1 !== t0 + 1) $display("FAIL bp_back_to_back: got gap %0d exp 1", t1 - t0); else n_pass++;
    end
    send_beat(2, 6'd3, 32'h0000_0F00, rand_line(), 1'b1, acc, wt);
    wait_got(1, ok);
    n_checks++; if (!ok) $display("FAIL bp_w2_seen: got %0d exp 1", got_q.size()); else n_pass++;
    if (ok) begin
      got = got_q.pop_front(); void'(got_t.pop_front()); exp = exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL bp_w2_wb: got %s exp %s", fmt_rec(got), fmt_rec(exp)); else n_pass++;
    end
  endtask

  task automatic test_overlap();
    int acc, wt;
    bit ok;
    logic [REC_W-1:0] got, exp;
    send_beat(0, 6'd7, 32'h0000_00FF, pat_line(32'h1000), 1'b0, acc, wt);
    n_checks++; if (err_overlap !== m_err) $display("FAIL overlap_err_first: got %0b exp %0b", err_overlap, m_err); else n_pass++;
    send_beat(0, 6'd7, 32'h0000_FFFF, pat_line(32'h2000), 1'b1, acc, wt);
    n_checks++; if (err_overlap !== m_err) $display("FAIL overlap_err_second: got %0b exp %0b", err_overlap, m_err); else n_pass++;
    wait_got(1, ok);
    n_checks++; if (!ok) $display("FAIL overlap_wb_seen: got %0d exp 1", got_q.size()); else n_pass++;
    if (ok) begin
      got = got_q.pop_front(); void'(got_t.pop_front()); exp = exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL overlap_wb: got %s exp %s", fmt_rec(got), fmt_rec(exp)); else n_pass++;
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (err_overlap !== m_err) $display("FAIL overlap_err_sticky: got %0b exp %0b", err_overlap, m_err); else n_pass++;
  endtask

  task automatic test_random();
    int acc, wt, w, idx, target;
    bit ok;
    logic [WARP_SIZE-1:0] mask;
    logic [REC_W-1:0] got, exp;
    for (int b = 0; b < 80; b++) begin
      wb_ready = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, NUM_WARPS - 1);
      case ($urandom_range(0, 4))
        0:       mask = '0;
        1:       mask = '1;
        2:       mask = 32'h0000_FFFF << ($urandom_range(0, 1) * 16);
        default: mask = $urandom();
      endcase
      send_beat(w, REG_W'($urandom_range(0, 63)), mask, rand_line(), ($urandom_range(0, 2) == 0), acc, wt);
    end
    for (int k = 0; k < NUM_WARPS; k++) begin
      if (m_active[k]) send_beat(k, m_rd[k], '0, rand_line(), 1'b1, acc, wt);
    end
    wb_ready = 1'b1;
    target = exp_q.size();
    wait_got(target, ok);
    n_checks++; if (!ok || got_q.size() !== target) $display("FAIL random_count: got %0d exp %0d", got_q.size(), target); else n_pass++;
    while (got_q.size() > 0) begin
      got = got_q.pop_front(); void'(got_t.pop_front());
      idx = -1;
      for (int j = 0; j < exp_q.size(); j++)
        if (idx < 0 && exp_q[j][REC_W-1 -: WID_W] == got[REC_W-1 -: WID_W]) idx = j;
      n_checks++;
      if (idx < 0) begin
        $display("FAIL random_wb_unexpected: got %s exp none", fmt_rec(got));
      end else begin
        exp = exp_q[idx];
        exp_q.delete(idx);
        if (got !== exp) $display("FAIL random_wb: got %s exp %s", fmt_rec(got), fmt_rec(exp));
        else n_pass++;
      end
    end
    n_checks++; if (err_overlap !== m_err) $display("FAIL random_err: got %0b exp %0b", err_overlap, m_err); else n_pass++;
    n_checks++; if (drv_timeouts !== 0) $display("FAIL random_driver: got %0d timeouts exp 0", drv_timeouts); else n_pass++;
  endtask

  task automatic test_reset_midop();
    int acc, wt;
    bit ok;
    logic [REC_W-1:0] got, exp;
    wb_ready = 1'b0;
    send_beat(3, 6'd20, 32'hFFFF_FFFF, rand_line(), 1'b1, acc, wt);
    send_beat(1, 6'd21, 32'h0000_FFFF, rand_line(), 1'b0, acc, wt);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({wb_valid, wb_warp, wb_rd, wb_mask, err_overlap} !== '0 || wb_data !== '0)
      $display("FAIL midreset_outputs: got v%0b %s err%0b exp all 0", wb_valid, fmt_rec({wb_warp, wb_rd, wb_mask, wb_data}), err_overlap);
    else n_pass++;
    n_checks++; if (dbg_slot_state !== '0) $display("FAIL midreset_slots: got %02h exp 00", dbg_slot_state); else n_pass++;
    rst = 1'b0;
    model_reset();
    wb_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (got_q.size() !== 0) $display("FAIL midreset_stale_wb: got %0d exp 0", got_q.size()); else n_pass++;
    send_beat(1, 6'd22, 32'h0000_000F, rand_line(), 1'b1, acc, wt);
    wait_got(1, ok);
    n_checks++; if (!ok) $display("FAIL midreset_wb_seen: got %0d exp 1", got_q.size()); else n_pass++;
    if (ok) begin
      got = got_q.pop_front(); void'(got_t.pop_front()); exp = exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL midreset_wb: got %s exp %s", fmt_rec(got), fmt_rec(exp)); else n_pass++;
    end
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if (got_q.size() !== 0) $display("FAIL midreset_single: got %0d extra exp 0", got_q.size()); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_coalesced();
    test_two_way_split();
    test_interleave();
    test_backpressure_rr();
    test_overlap();
    test_random();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion exp finish before 2000000");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/lsu_response_merger.md
# lsu_response_merger

Return-path counterpart of the SM's LSU transaction splitter. The splitter breaks one warp memory instruction into one or more per-cache-line transactions, each with a lane sub-mask and a last flag. This block accepts the memory responses for those transactions in any warp interleaving and accumulates lane data per warp. Once the last split of a warp has arrived, it emits a single merged register writeback to the writeback stage.

## Interface
- `WARP_SIZE`, 32: lanes per warp.
- `NUM_WARPS`, 4: warps tracked; one accumulation slot per warp.
- `DATA_W`, 32: bits per lane.
- `REG_W`, 6: destination register index width (64 regs).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `resp_valid` in 1: response beat valid.
- `resp_ready` out 1: beat accepted when `resp_valid && resp_ready`.
- `resp_warp` in $clog2(NUM_WARPS): warp owning the beat.
- `resp_rd` in REG_W: destination register.
- `resp_mask` in WARP_SIZE: lanes carried by this beat.
- `resp_data` in WARP_SIZE*DATA_W: lane i at bits [i*DATA_W +: DATA_W].
- `resp_last` in 1: final split of this warp's instruction.
- `wb_valid` out 1: merged writeback valid.
- `wb_ready` in 1: writeback consumer ready.
- `wb_warp` out $clog2(NUM_WARPS): warp of the writeback.
- `wb_rd` out REG_W: destination register.
- `wb_mask` out WARP_SIZE: OR of all accepted beat masks.
- `wb_data` out WARP_SIZE*DATA_W: merged lane data; lanes outside `wb_mask` read 0.
- `err_overlap` out 1: sticky error flag (see Configuration).

## Operation
- Each warp slot is a 3-state FSM: IDLE, ACCUM, DONE.
- **IDLE + accepted beat:**
  - Clear the slot's data and mask.
  - Capture `resp_rd`.
  - Write the masked lanes and set the slot mask to `resp_mask`.
  - Move to DONE if `resp_last`, else to ACCUM.
- **ACCUM + accepted beat:**
  - Write the masked lanes; lanes outside `resp_mask` keep their value.
  - OR `resp_mask` into the slot mask.
  - `resp_rd` is ignored; the first beat's rd is kept.
  - Move to DONE if `resp_last`.
- **DONE:** the slot is eligible for writeback; it moves to IDLE on the `wb_valid && wb_ready` handshake.
- `resp_ready` = slot state of `resp_warp` is not DONE. It is combinational on `resp_warp` only and never depends on `resp_valid`.
- **Writeback arbiter:** round-robin over DONE slots.
  - The pointer starts at warp 0.
  - After each handshake, the pointer moves to granted warp + 1, modulo NUM_WARPS.
- **Output register:**
  - Registered; it holds the selected slot's `wb_*` stable while `wb_valid && !wb_ready`.
  - The selection does not change until the handshake completes.
- A beat with `resp_mask == 0` is legal: it updates state and flags only.

## Timing
- Reset values: `wb_valid=0`, `wb_warp=0`, `wb_rd=0`, `wb_mask=0`, `wb_data=0`, `err_overlap=0`. All slots are IDLE and the RR pointer is 0.
- A final beat accepted at edge N gives `wb_valid=1` from the cycle after N (latency 1) when the output is free and the arbiter selects that warp.
- Back-to-back writebacks: 1 per cycle while `wb_ready=1` and DONE slots exist.
- When a warp's writeback handshakes at edge N, the slot is IDLE after N. A new beat for that warp can be accepted at edge N+1. There is no same-cycle bypass.
- Beats for other warps are accepted every cycle, independent of writeback backpressure.
- Reset asserted mid-accumulation discards all partial slots and any pending writeback; no writeback is emitted for them.

## Configuration
- `LSU_MERGE_OVERLAP_CHECK_EN` defined:
  - `err_overlap` is set on any accepted ACCUM beat where (`resp_mask & slot_mask`) != 0, or `resp_rd` != the captured rd.
  - It stays set until `rst`.
  - Data for overlapping lanes still takes the later beat.
- Undefined: the check logic is not built and `err_overlap` is tied to 0.

## Test plan
- **Coalesced:** warp 0, rd=5, mask FFFFFFFF, last=1, lane i data = 0x100+i.
  - Required: `wb_valid` in the next cycle with warp 0, rd 5, mask FFFFFFFF, lane i = 0x100+i; exactly one writeback.
- **Two-way split:** warp 1 beat {mask 0000FFFF, data 0xA000+i, last=0}, then {mask FFFF0000, data 0xB000+i, last=1}.
  - Required: no writeback after the first beat.
  - Then one writeback with mask FFFFFFFF, lanes 0-15 = 0xA000+i, lanes 16-31 = 0xB000+i.
- **Interleave:** warp 2 beat (last=0), then warp 3 beat (last=1), then warp 2 beat (last=1).
  - Required: the warp 3 writeback precedes the warp 2 writeback; each carries only its own lanes.
- **Backpressure + RR:** hold `wb_ready=0`, complete warps 0 and 1.
  - `resp_ready=0` for a warp 0 beat, `=1` for a warp 2 beat.
  - `wb_*` stays stable while stalled.
  - Raising `wb_ready` gives warp 0 then warp 1 on consecutive cycles.
- **Overlap (macro on):** warp 0 masks 000000FF then 0000FFFF (last).
  - `err_overlap=1` from the second beat, sticky.
  - Lanes 0-7 hold second-beat data.
  - With the macro off, `err_overlap` stays 0.
- **Reset mid-op:** warp 1 first beat, then `rst` for 1 cycle, then a single beat mask 0000000F, last=1.
  - Outputs are 0 during reset.
  - Then exactly one writeback with mask 0000000F; no stale lanes.
